// File: rtl/led_matrix_scan_driver_if.sv
// led_matrix_scan_driver_if: grid inputs, scan control and LED drive outputs of the matrix scanner
interface led_matrix_scan_driver_if;
    logic         enable;
    logic [255:0] frog_grid;
    logic [255:0] car_grid;
    logic [15:0]  row_sel;
    logic [15:0]  green_array;
    logic [15:0]  red_array;
    logic         frame_done;
    logic         hit;
    modport master (
        output enable, frog_grid, car_grid,
        input  row_sel, green_array, red_array, frame_done, hit
    );
    modport slave (
        input  enable, frog_grid, car_grid,
        output row_sel, green_array, red_array, frame_done, hit
    );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver: snapshots the frog/car grids per frame and scans them row by row onto the LED matrix
module led_matrix_scan_driver #(
    parameter int ROW_DWELL    = 500,
    parameter int BLANK_CYCLES = 4
) (
    input logic                     clk,
    input logic                     reset,
    led_matrix_scan_driver_if.slave bus
);
    localparam int CMAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
    localparam int CW = $clog2((CMAX > 2) ? CMAX : 2);
    localparam logic [CW-1:0] DW_LAST = CW'(ROW_DWELL - 1);
    localparam logic [CW-1:0] BL_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, LATCH, BLANK, DRIVE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    row_q, row_d;
    logic [255:0]  frog_sh_q, frog_sh_d, car_sh_q, car_sh_d;
    logic [15:0]   row_sel_q, row_sel_d, green_q, green_d, red_q, red_d;
    logic          frame_done_q, frame_done_d, hit_q, hit_d, step;
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        frog_sh_d    = frog_sh_q;
        car_sh_d     = car_sh_q;
        frame_done_d = 1'b0;
        step         = cnt_q == ((state_q == DRIVE) ? DW_LAST : BL_LAST);
        case (state_q)
            IDLE:  state_d = bus.enable ? LATCH : IDLE;
            LATCH: begin
                frog_sh_d = bus.frog_grid;
                car_sh_d  = bus.car_grid;
                row_d     = 4'd0;
                state_d   = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
            end
            BLANK: state_d = step ? DRIVE : BLANK;
            default: if (step) begin
                row_d        = row_q + 4'd1;
                frame_done_d = row_q == 4'd15;
                state_d      = (row_q != 4'd15) ? ((BLANK_CYCLES > 0) ? BLANK : DRIVE)
                                                : (bus.enable ? LATCH : IDLE);
            end
        endcase
        // counter restarts from zero whenever a timed state is (re)entered
        cnt_d     = ((state_q == BLANK || state_q == DRIVE) && !step) ? cnt_q + 1'b1 : '0;
        row_sel_d = (state_d == DRIVE) ? 16'(1) << row_d : '0;
        green_d   = (state_d == DRIVE) ? frog_sh_d[16*row_d +: 16] : '0;
        red_d     = (state_d == DRIVE) ? car_sh_d[16*row_d +: 16] : '0;
        hit_d     = |(bus.frog_grid & bus.car_grid);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            frog_sh_q    <= '0;
            car_sh_q     <= '0;
            row_sel_q    <= '0;
            green_q      <= '0;
            red_q        <= '0;
            frame_done_q <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            frog_sh_q    <= frog_sh_d;
            car_sh_q     <= car_sh_d;
            row_sel_q    <= row_sel_d;
            green_q      <= green_d;
            red_q        <= red_d;
            frame_done_q <= frame_done_d;
            hit_q        <= hit_d;
        end
    end
    assign bus.row_sel     = row_sel_q;
    assign bus.green_array = green_q;
    assign bus.red_array   = red_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.hit         = hit_q;
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb_led_matrix_scan_driver: directed scan, snapshot, enable, collision and async-reset checks at ROW_DWELL=4, BLANK_CYCLES=2
module tb_led_matrix_scan_driver;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_run = 0;
    int n_fail = 0;
    logic [255:0] fg1, cg1, fg2, cg3;
    led_matrix_scan_driver_if bus ();
    led_matrix_scan_driver #(.ROW_DWELL(4), .BLANK_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, " row_sel"}, 32'(bus.row_sel), 0);
        check({tag, " green"}, 32'(bus.green_array), 0);
        check({tag, " red"}, 32'(bus.red_array), 0);
        check({tag, " frame_done"}, 32'(bus.frame_done), 0);
        check({tag, " hit"}, 32'(bus.hit), 0);
    endtask
    // frame layout: k=0 LATCH, then per row 2 blank + 4 drive cycles (97 total)
    task automatic scan_frame(input int f, input logic [255:0] fg, input logic [255:0] cg,
                              input logic fd0, input int act);
        int r;
        logic drv;
        string t;
        for (int k = 0; k < 97; k++) begin
            r   = (k == 0) ? 0 : (k - 1) / 6;
            drv = (k != 0) && (((k - 1) % 6) >= 2);
            t   = $sformatf("f%0d k%0d", f, k);
            check({t, " row_sel"}, 32'(bus.row_sel), drv ? 32'(16'(1) << r) : 0);
            check({t, " green"}, 32'(bus.green_array), drv ? 32'(fg[16*r +: 16]) : 0);
            check({t, " red"}, 32'(bus.red_array), drv ? 32'(cg[16*r +: 16]) : 0);
            check({t, " frame_done"}, 32'(bus.frame_done), (k == 0) ? 32'(fd0) : 0);
            check({t, " onehot0"}, 32'($onehot0(bus.row_sel)), 1);
            if (act == 1 && k == 15) bus.frog_grid[95:80] = 16'hFFFF;
            if (act == 2 && k == 52) bus.enable = 1'b0;
            if (act == 3 && k == 60) bus.car_grid[7] = 1'b1;
            if (act == 3 && k == 64) begin
                check({t, " hit_before_reset"}, 32'(bus.hit), 1);
                #2 reset = 1'b1;
                #1 check_zero({t, " async_reset"});
                return;
            end
            @(negedge clk);
        end
    endtask
    initial begin
        bus.enable    = 1'b0;
        bus.frog_grid = '0;
        bus.car_grid  = '0;
        #1 reset = 1'b1;
        #2 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle");
        bus.frog_grid[7] = 1'b1;
        bus.car_grid[7]  = 1'b1;
        check("hit_latency", 32'(bus.hit), 0);
        @(negedge clk);
        check("hit_set", 32'(bus.hit), 1);
        check("hit_idle row_sel", 32'(bus.row_sel), 0);
        bus.car_grid[7] = 1'b0;
        @(negedge clk);
        check("hit_clear", 32'(bus.hit), 0);
        bus.car_grid[63:48] = 16'hF000;
        fg1 = bus.frog_grid;
        cg1 = bus.car_grid;
        bus.enable = 1'b1;
        @(negedge clk);
        scan_frame(1, fg1, cg1, 1'b0, 1);
        fg2 = fg1;
        fg2[95:80] = 16'hFFFF;
        scan_frame(2, fg2, cg1, 1'b1, 2);
        check("f2_end frame_done", 32'(bus.frame_done), 1);
        check("f2_end row_sel", 32'(bus.row_sel), 0);
        repeat (3) begin
            @(negedge clk);
            check_zero("idle_after_stop");
        end
        bus.enable = 1'b1;
        @(negedge clk);
        scan_frame(3, fg2, cg1, 1'b0, 3);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cg3 = cg1;
        cg3[7] = 1'b1;
        scan_frame(4, fg2, cg3, 1'b0, 0);
        check("f4_end frame_done", 32'(bus.frame_done), 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
